// File: rtl/sao_pkg.sv
// Shared types and helpers for the SAO LCU scheduler.
package sao_pkg;

  localparam int unsigned FRAME_LOG2 = 7;

  typedef enum logic [1:0] {
    LCU_16      = 2'd0,
    LCU_32      = 2'd1,
    LCU_64      = 2'd2,
    LCU_ILLEGAL = 2'd3
  } lcu_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_WAIT_RDY,
    S_STREAM,
    S_WAIT_ACK,
    S_WAIT_PROC,
    S_DONE
  } state_e;

  // par_data field positions
  localparam int unsigned PAR_TYPE_LSB = 22;
  localparam int unsigned PAR_BAND_LSB = 17;
  localparam int unsigned PAR_EO_BIT   = 16;
  localparam int unsigned PAR_OFF_LSB  = 0;

  // log2 of the LCU edge length
  function automatic logic [2:0] lcu_log2(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd4;
      2'd1:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  // highest LCU index per axis (grid size minus one)
  function automatic logic [2:0] grid_last(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd7;
      2'd1:    return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/sao_lcu_addr_gen.sv
// Combinational frame-buffer address for pixel p of LCU (lcu_x, lcu_y).
module sao_lcu_addr_gen
  import sao_pkg::*;
#(
  parameter int unsigned AW    = 14,
  parameter int unsigned LOG2W = FRAME_LOG2
) (
  input  logic [2:0]    lcu_x,
  input  logic [2:0]    lcu_y,
  input  logic [11:0]   p,
  input  logic [1:0]    size,
  output logic [AW-1:0] fb_addr
);

  logic [2:0]  l2;
  logic [11:0] px;
  logic [11:0] py;

  // split p into row/column inside the LCU and form the raster address
  always_comb begin
    l2      = lcu_log2(size);
    py      = p >> l2;
    px      = p & ~(12'hFFF << l2);
    fb_addr = (AW'(lcu_y) << (LOG2W + 32'(l2)))
            + (AW'(lcu_x) << l2)
            + (AW'(py) << LOG2W)
            + AW'(px);
  end

endmodule

// File: rtl/sao_lcu_sched.sv
// Frame-level SAO scheduler: walks LCUs in raster order, takes one parameter
// set per LCU, streams its pixels into the engine and tracks engine status.
module sao_lcu_sched
  import sao_pkg::*;
#(
  parameter int unsigned FRAME_W = 128,
  parameter int unsigned AW      = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cfg_lcu_size,
  input  logic          par_valid,
  input  logic [23:0]   par_data,
  output logic          par_ready,
  output logic          fb_ren,
  output logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_q,
  output logic          sao_in_en,
  output logic [7:0]    sao_din,
  output logic [1:0]    sao_type,
  output logic [4:0]    sao_band_pos,
  output logic          sao_eo_class,
  output logic [15:0]   sao_offset,
  output logic [2:0]    sao_lcu_x,
  output logic [2:0]    sao_lcu_y,
  output logic [1:0]    sao_lcu_size,
  input  logic          sao_busy,
  input  logic          sao_finish,
  output logic          frame_busy,
  output logic          done,
  output logic          err
);

  state_e        state, state_nx;
  logic [1:0]    size_q;
  logic [2:0]    lcu_x, lcu_y;
  logic [11:0]   p;
  logic [11:0]   p_last;
  logic [2:0]    l2;
  logic          last_lcu;
  logic          size_ok;
  logic [AW-1:0] addr;

  sao_lcu_addr_gen #(
    .AW    (AW),
    .LOG2W ($clog2(FRAME_W))
  ) u_addr (
    .lcu_x   (lcu_x),
    .lcu_y   (lcu_y),
    .p       (p),
    .size    (size_q),
    .fb_addr (addr)
  );

  // per-frame geometry derived from the latched LCU size
  always_comb begin
    l2       = lcu_log2(size_q);
    p_last   = ~(12'hFFF << {l2, 1'b0});
    last_lcu = (lcu_x == grid_last(size_q)) && (lcu_y == grid_last(size_q));
    size_ok  = (cfg_lcu_size != LCU_ILLEGAL);
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_nx   = state;
    par_ready  = 1'b0;
    fb_ren     = 1'b0;
    done       = 1'b0;
    frame_busy = 1'b1;
    case (state)
      S_IDLE: begin
        frame_busy = 1'b0;
        if (start && size_ok) state_nx = S_PARAM;
      end
      S_PARAM: begin
        par_ready = 1'b1;
        if (par_valid) state_nx = S_WAIT_RDY;
      end
      S_WAIT_RDY: if (!sao_busy) state_nx = S_STREAM;
      S_STREAM: begin
        fb_ren = 1'b1;
        if (p == p_last) state_nx = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (sao_busy) state_nx = S_WAIT_PROC;
      S_WAIT_PROC: begin
        // the last LCU waits for the engine's frame finish, not busy release
        if (last_lcu) begin
          if (sao_finish) state_nx = S_DONE;
        end else if (!sao_busy) begin
          state_nx = S_PARAM;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        frame_busy = 1'b0;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    fb_addr = fb_ren ? addr : '0;
    sao_din = sao_in_en ? fb_q : '0;
  end

  // LCU position, pixel counter, context registers and pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q       <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
      p            <= '0;
      sao_in_en    <= 1'b0;
      err          <= 1'b0;
      sao_type     <= '0;
      sao_band_pos <= '0;
      sao_eo_class <= 1'b0;
      sao_offset   <= '0;
      sao_lcu_x    <= '0;
      sao_lcu_y    <= '0;
      sao_lcu_size <= '0;
    end else begin
      err       <= (state == S_IDLE) && start && !size_ok;
      sao_in_en <= (state == S_STREAM);
      case (state)
        S_IDLE: begin
          if (start && size_ok) begin
            size_q <= cfg_lcu_size;
            lcu_x  <= '0;
            lcu_y  <= '0;
          end
        end
        S_PARAM: begin
          if (par_valid) begin
            sao_type     <= par_data[PAR_TYPE_LSB +: 2];
            sao_band_pos <= par_data[PAR_BAND_LSB +: 5];
            sao_eo_class <= par_data[PAR_EO_BIT];
            sao_offset   <= par_data[PAR_OFF_LSB +: 16];
            sao_lcu_x    <= lcu_x;
            sao_lcu_y    <= lcu_y;
            sao_lcu_size <= size_q;
          end
        end
        S_STREAM: p <= (p == p_last) ? '0 : p + 12'd1;
        S_WAIT_PROC: begin
          if (!last_lcu && !sao_busy) begin
            if (lcu_x == grid_last(size_q)) begin
              lcu_x <= '0;
              lcu_y <= lcu_y + 3'd1;
            end else begin
              lcu_x <= lcu_x + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sao_lcu_sched.sv
// Directed bench for sao_lcu_sched with a frame-buffer and SAO engine model.
module tb_sao_lcu_sched;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  cfg_lcu_size;
  logic        par_valid, par_ready;
  logic [23:0] par_data;
  logic        fb_ren;
  logic [13:0] fb_addr;
  logic [7:0]  fb_q;
  logic        sao_in_en;
  logic [7:0]  sao_din;
  logic [1:0]  sao_type;
  logic [4:0]  sao_band_pos;
  logic        sao_eo_class;
  logic [15:0] sao_offset;
  logic [2:0]  sao_lcu_x, sao_lcu_y;
  logic [1:0]  sao_lcu_size;
  logic        sao_busy, sao_finish;
  logic        frame_busy, done, err;

  always #5 clk = ~clk;

  sao_lcu_sched #(.FRAME_W(128), .AW(14)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .par_valid(par_valid), .par_data(par_data), .par_ready(par_ready),
    .fb_ren(fb_ren), .fb_addr(fb_addr), .fb_q(fb_q),
    .sao_in_en(sao_in_en), .sao_din(sao_din),
    .sao_type(sao_type), .sao_band_pos(sao_band_pos), .sao_eo_class(sao_eo_class),
    .sao_offset(sao_offset), .sao_lcu_x(sao_lcu_x), .sao_lcu_y(sao_lcu_y),
    .sao_lcu_size(sao_lcu_size), .sao_busy(sao_busy), .sao_finish(sao_finish),
    .frame_busy(frame_busy), .done(done), .err(err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame geometry and model state
  logic [1:0]  cur_size = 2'd0;
  int          cur_n = 16, grid_g = 8, npix = 256, total = 64;
  int          k_par, k_str, p_exp, lcu_inen, inen_cnt, done_cnt, proc;
  int          withhold, hold_cnt, hold_lcu = -1;
  int          cyc, drop_cyc, first_cyc;
  bit          hold_mark, want_first, prev_busy, drop_pending;
  logic [31:0] exp_ctx;
  logic [7:0]  prev_q;
  logic        ren_s;
  logic [13:0] addr_s, a_m, p16_addr;
  logic [13:0] first_addr [64];
  logic [13:0] last_addr  [64];

  function automatic logic [13:0] model_addr(input int k, input int p);
    int lx, ly, row, col;
    lx  = k % grid_g;
    ly  = k / grid_g;
    row = p / cur_n;
    col = p % cur_n;
    return 14'((ly * cur_n + row) * 128 + lx * cur_n + col);
  endfunction

  function automatic logic [23:0] par_word(input int k);
    logic [23:0] w;
    w[23:22] = 2'(k % 3);
    w[21:17] = 5'(k + 1);
    w[16]    = k[0];
    w[15:0]  = 16'(32'hA500 + k);
    return w;
  endfunction

  function automatic logic [31:0] ctx_word(input int k);
    logic [23:0] w;
    w = par_word(k);
    return {w, 3'(k % grid_g), 3'(k / grid_g), cur_size};
  endfunction

  task automatic env_clear();
    k_par = 0; k_str = 0; p_exp = 0; lcu_inen = 0; inen_cnt = 0; proc = 0;
    hold_cnt = 0; hold_mark = 0; want_first = 0; prev_busy = 0; drop_pending = 0;
    exp_ctx = '0; prev_q = '0; ren_s = 1'b0; addr_s = '0;
  endtask

  // frame buffer, parameter source and SAO engine model
  initial begin
    par_valid = 1'b0; par_data = '0; sao_busy = 1'b0; sao_finish = 1'b0; fb_q = '0;
    env_clear();
    done_cnt = 0; withhold = 0; cyc = 0; drop_cyc = 0; first_cyc = 0; p16_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        env_clear();
      end else begin
        check("ctx", {sao_type, sao_band_pos, sao_eo_class, sao_offset,
                      sao_lcu_x, sao_lcu_y, sao_lcu_size}, exp_ctx);
        if (hold_mark && prev_busy && !sao_busy && hold_cnt == 0) begin
          drop_cyc = cyc; hold_mark = 0; want_first = 1;
        end
        prev_busy = sao_busy;
        if (par_ready && !par_valid && withhold > 0) begin
          withhold--;
          check("ren_in_param", fb_ren, 0);
        end
        if (par_ready && par_valid) begin
          if (k_par > 0) check("inen_cnt", lcu_inen, npix);
          lcu_inen = 0;
          if (k_par < 64) exp_ctx = ctx_word(k_par);
          if (k_par == hold_lcu) begin hold_cnt = 5; hold_mark = 1; end
          k_par++;
        end
        if (sao_in_en) begin
          check("din", sao_din, prev_q);
          lcu_inen++; inen_cnt++;
        end
        ren_s = fb_ren; addr_s = fb_addr;
        if (fb_ren) begin
          a_m = model_addr(k_str, p_exp);
          if (want_first && p_exp == 0) begin first_cyc = cyc; want_first = 0; end
          if (k_str < 64) begin
            if (p_exp == 0) first_addr[k_str] = fb_addr;
            last_addr[k_str] = fb_addr;
          end
          if (k_str == 0 && p_exp == 16) p16_addr = fb_addr;
          check("fb_addr", fb_addr, a_m);
          prev_q = a_m[7:0];
          p_exp++;
          if (p_exp == npix) begin p_exp = 0; k_str++; end
        end else if (p_exp != 0) begin
          check("ren_gap", fb_ren, 1);
        end
        if (done) begin
          done_cnt++;
          check("done_lcus", k_str, total);
          check("inen_last", lcu_inen, npix);
        end
      end
      @(posedge clk);
      #1;
      sao_finish = 1'b0;
      if (reset) begin
        sao_busy = 1'b0; fb_q = '0; par_valid = 1'b0;
      end else begin
        if (ren_s) fb_q = addr_s[7:0];
        if (hold_cnt > 0) begin
          sao_busy = 1'b1; hold_cnt--;
          if (hold_cnt == 0) drop_pending = 1;
        end else if (drop_pending) begin
          sao_busy = 1'b0; drop_pending = 0;
        end else if (inen_cnt >= npix) begin
          sao_busy = 1'b1; proc = 2; inen_cnt = 0;
        end else if (proc > 0) begin
          proc--;
          if (proc == 0) begin
            sao_busy = 1'b0;
            sao_finish = (k_str >= total);
          end
        end
        par_valid = (withhold == 0) && (k_par < total);
        par_data  = par_word(k_par);
      end
    end
  end

  task automatic start_frame(input logic [1:0] size);
    @(posedge clk); #3;
    cur_size = size;
    cur_n = 16 << size; grid_g = 128 / cur_n; npix = cur_n * cur_n; total = grid_g * grid_g;
    k_par = 0; k_str = 0; p_exp = 0; lcu_inen = 0; inen_cnt = 0; done_cnt = 0;
    cfg_lcu_size = size; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
    check("fbusy_on", frame_busy, 1);
    check("pready_on", par_ready, 1);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_done"}, done_cnt, 1);
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_fbusy_off"}, frame_busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_lcu_size = 2'd0;
    #13;
    check("rst_out", {fb_ren, fb_addr, sao_in_en, sao_din, par_ready, frame_busy, done, err}, 0);
    check("rst_ctx", {sao_type, sao_band_pos, sao_eo_class, sao_offset,
                      sao_lcu_x, sao_lcu_y, sao_lcu_size}, 0);
    @(posedge clk); #3;
    reset = 1'b0;

    // illegal size: err pulse only
    @(posedge clk); #3;
    cfg_lcu_size = 2'd3; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_fbusy", frame_busy, 0);
    @(posedge clk); #3;
    check("err_clear", err, 0);
    check("err_idle", par_ready, 0);

    // 64x64: withheld params on LCU0, engine busy hold on LCU1, stray start
    withhold = 10; hold_lcu = 1;
    start_frame(2'd2);
    repeat (3000) @(posedge clk);
    #3;
    cfg_lcu_size = 2'd0; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0; cfg_lcu_size = 2'd2;
    wait_done("s2", 20000);
    check("s2_lcus", k_str, 4);
    check("s2_first3", first_addr[3], 8256);
    check("s2_last3", last_addr[3], 16383);
    check("busy_to_stream", first_cyc - drop_cyc, 1);
    hold_lcu = -1;

    // 16x16 full frame
    start_frame(2'd0);
    wait_done("s0", 20000);
    check("s0_lcus", k_str, 64);
    check("s0_first1", first_addr[1], 16);
    check("s0_p16", p16_addr, 128);

    // 32x32: reset mid-stream at p=100, then full frame from LCU(0,0)
    start_frame(2'd1);
    for (int i = 0; i < 2000 && p_exp != 100; i++) begin
      @(negedge clk); #1;
    end
    check("reach_p100", p_exp, 100);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_out", {fb_ren, fb_addr, sao_in_en, sao_din, par_ready, frame_busy, done, err}, 0);
    check("arst_ctx", {sao_type, sao_band_pos, sao_eo_class, sao_offset,
                       sao_lcu_x, sao_lcu_y, sao_lcu_size}, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    start_frame(2'd1);
    wait_done("s1", 20000);
    check("s1_lcus", k_str, 16);
    check("s1_first0", first_addr[0], 0);
    check("s1_first5", first_addr[5], 4128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
